// File: rtl/dino_input_conditioner_if.sv
// Button and frame signals between the board pins,
// the input conditioner and the processor/VGA side.
interface dino_input_conditioner_if;
  logic       up;
  logic       down;
  logic       screen_end;
  logic       io_jump;
  logic       duck;
  logic       jump_pending;
  logic [7:0] jump_count;

  modport master (
    output up,
    output down,
    output screen_end,
    input  io_jump,
    input  duck,
    input  jump_pending,
    input  jump_count
  );

  modport slave (
    input  up,
    input  down,
    input  screen_end,
    output io_jump,
    output duck,
    output jump_pending,
    output jump_count
  );
endinterface

// File: rtl/dino_input_conditioner.sv
// Sync, debounce and frame-aligned jump delivery for
// the up/down push-buttons.
module dino_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic                     clock,
  input logic                     reset,
  dino_input_conditioner_if.slave bus
);

  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 = up (jump), bit 1 = down (duck)
  logic [1:0] raw;
  logic [1:0] sync_m;
  logic [1:0] sync_s;
  logic [1:0] lvl_nxt;
  logic [1:0] lvl_q;

  logic       rise_up;
  logic       io_jump_q;
  logic       pend_q;
  logic [7:0] count_q;

  assign raw = {bus.down, bus.up};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_m <= '0;
      sync_s <= '0;
    end else begin
      sync_m <= raw;
      sync_s <= sync_m;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_db
    logic [1:0]       st;
    logic [1:0]       st_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             s;
    logic             done;

    assign s    = sync_s[b];
    assign done = (cnt == LAST);

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      unique case (st)
        S_LOW: begin
          if (s) begin
            st_n  = S_WAIT_HIGH;
            cnt_n = '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!s) begin
            st_n  = S_LOW;
            cnt_n = '0;
          end else if (done) begin
            st_n  = S_HIGH;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!s) begin
            st_n  = S_WAIT_LOW;
            cnt_n = '0;
          end
        end
        S_WAIT_LOW: begin
          if (s) begin
            st_n  = S_HIGH;
            cnt_n = '0;
          end else if (done) begin
            st_n  = S_LOW;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          st_n  = S_LOW;
          cnt_n = '0;
        end
      endcase
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        st  <= S_LOW;
        cnt <= '0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
      end
    end

    assign lvl_nxt[b] = (st_n == S_HIGH) ||
                        (st_n == S_WAIT_LOW);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_nxt;
    end
  end

  // only WAIT_HIGH -> HIGH can raise the level
  assign rise_up = lvl_nxt[0] & ~lvl_q[0];

  // a press landing on the strobe stays pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_jump_q <= 1'b0;
      pend_q    <= 1'b0;
      count_q   <= '0;
    end else if (bus.screen_end) begin
      io_jump_q <= pend_q;
      pend_q    <= rise_up;
      if (pend_q) begin
        count_q <= count_q + 8'd1;
      end
    end else begin
      pend_q <= pend_q | rise_up;
    end
  end

  assign bus.io_jump      = io_jump_q;
  assign bus.duck         = lvl_q[1];
  assign bus.jump_pending = pend_q;
  assign bus.jump_count   = count_q;

endmodule

// File: tb/tb_dino_input_conditioner.sv
// Randomised and directed bench for the input conditioner
// against a pin-history reference model.
module tb_dino_input_conditioner;

  localparam int D  = 4;
  localparam int HW = D + 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int total = 0;
  int bad   = 0;

  dino_input_conditioner_if bus ();

  dino_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: the level flips once the pin, seen two edges
  // late, has held the new value for D+1 samples.
  logic [HW-1:0] uh = '0;
  logic [HW-1:0] dh = '0;
  bit ulev = 0;
  bit dlev = 0;
  bit m_pend = 0;
  bit m_io = 0;
  int m_cnt = 0;

  always @(posedge clock) begin
    bit rise;
    rise = 0;
    if (!reset) begin
      uh = '0;
      dh = '0;
      ulev = 0;
      dlev = 0;
      m_pend = 0;
      m_io = 0;
      m_cnt = 0;
    end else begin
      uh = {uh[HW-2:0], bus.up};
      dh = {dh[HW-2:0], bus.down};
      if (!ulev && (&uh[HW-1:2])) begin
        ulev = 1;
        rise = 1;
      end else if (ulev && !(|uh[HW-1:2])) begin
        ulev = 0;
      end
      if (!dlev && (&dh[HW-1:2])) dlev = 1;
      else if (dlev && !(|dh[HW-1:2])) dlev = 0;
      if (bus.screen_end) begin
        m_io = m_pend;
        if (m_pend) m_cnt = (m_cnt + 1) % 256;
        m_pend = rise;
      end else begin
        m_pend = m_pend | rise;
      end
    end
    #1;
    chk("io_jump", int'(bus.io_jump), int'(m_io));
    chk("duck", int'(bus.duck), int'(dlev));
    chk("jump_pending", int'(bus.jump_pending),
        int'(m_pend));
    chk("jump_count", int'(bus.jump_count), m_cnt);
  end

  task automatic ticks(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic strobe();
    bus.screen_end = 1'b1;
    @(negedge clock);
    bus.screen_end = 1'b0;
    @(negedge clock);
  endtask

  task automatic press();
    bus.up = 1'b1;
    ticks(8);
    bus.up = 1'b0;
    ticks(8);
  endtask

  initial begin
    int lat;
    int c0;
    bus.up = 1'b1;
    bus.down = 1'b1;
    bus.screen_end = 1'b0;

    // reset held with buttons and strobes active
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.screen_end = (i % 3 == 0);
    end
    @(negedge clock);
    bus.screen_end = 1'b0;
    chk("rst_io", int'(bus.io_jump), 0);
    chk("rst_duck", int'(bus.duck), 0);
    chk("rst_pend", int'(bus.jump_pending), 0);
    chk("rst_cnt", int'(bus.jump_count), 0);

    reset = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.jump_pending) begin
        lat = i;
        break;
      end
    end
    chk("release_latency", lat, 2 + D + 1);
    chk("release_duck", int'(bus.duck), 1);
    @(negedge clock);
    bus.up = 1'b0;
    bus.down = 1'b0;
    ticks(10);
    strobe();
    chk("first_io", int'(bus.io_jump), 1);
    chk("first_cnt", int'(bus.jump_count), 1);
    strobe();
    chk("first_io_off", int'(bus.io_jump), 0);

    // glitches shorter than the debounce window
    for (int k = 0; k < 2; k++) begin
      bus.up = 1'b1;
      bus.down = 1'b1;
      ticks(3);
      bus.up = 1'b0;
      bus.down = 1'b0;
      ticks(3);
    end
    ticks(10);
    chk("glitch_pend", int'(bus.jump_pending), 0);
    chk("glitch_duck", int'(bus.duck), 0);

    // clean press
    bus.up = 1'b1;
    ticks(10);
    bus.up = 1'b0;
    chk("clean_pend", int'(bus.jump_pending), 1);
    ticks(20);
    chk("clean_pend_hold", int'(bus.jump_pending), 1);
    strobe();
    chk("clean_io", int'(bus.io_jump), 1);
    chk("clean_cnt", int'(bus.jump_count), 2);
    strobe();
    chk("clean_io_off", int'(bus.io_jump), 0);

    // coalescing
    press();
    press();
    press();
    strobe();
    chk("coal_cnt", int'(bus.jump_count), 3);
    chk("coal_pend", int'(bus.jump_pending), 0);
    strobe();
    chk("coal_io_off", int'(bus.io_jump), 0);

    // collision: rise_up lands on the strobe cycle
    bus.up = 1'b1;
    ticks(6);
    bus.screen_end = 1'b1;
    @(negedge clock);
    bus.screen_end = 1'b0;
    chk("coll_io", int'(bus.io_jump), 0);
    chk("coll_pend", int'(bus.jump_pending), 1);
    ticks(4);
    bus.up = 1'b0;
    ticks(10);
    strobe();
    chk("coll_io_next", int'(bus.io_jump), 1);
    chk("coll_cnt", int'(bus.jump_count), 4);

    // wrap: 252 more framed presses bring 4 back to 0
    for (int i = 0; i < 252; i++) begin
      press();
      strobe();
    end
    chk("wrap_cnt", int'(bus.jump_count), 0);
    strobe();

    // random phase, strobe never held
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) bus.up = ~bus.up;
      if ($urandom_range(0, 7) == 0)
        bus.down = ~bus.down;
      if (bus.screen_end) bus.screen_end = 1'b0;
      else bus.screen_end = ($urandom_range(0, 19) == 0);
    end
    bus.up = 1'b0;
    bus.down = 1'b0;
    bus.screen_end = 1'b0;
    ticks(12);
    strobe();
    strobe();

    // reset mid-debounce with a delivery in flight
    c0 = int'(bus.jump_count);
    press();
    strobe();
    chk("mid_io", int'(bus.io_jump), 1);
    chk("mid_cnt", int'(bus.jump_count), (c0 + 1) % 256);
    press();
    bus.up = 1'b1;
    ticks(3);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_io", int'(bus.io_jump), 0);
    chk("async_pend", int'(bus.jump_pending), 0);
    chk("async_cnt", int'(bus.jump_count), 0);
    chk("async_duck", int'(bus.duck), 0);
    @(negedge clock);
    bus.up = 1'b0;
    ticks(2);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ticks(8);
      strobe();
      chk("post_io", int'(bus.io_jump), 0);
    end
    chk("post_cnt", int'(bus.jump_count), 0);
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dino_input_conditioner.md
Name: dino_input_conditioner

Overview:
- Conditions the raw board push-buttons (up, down) before they reach the processor's io_jump input and the VGA controller's duck control.
- Synchronises, debounces and edge-detects each button.
- A jump press is latched and delivered to the processor as a request aligned to the 60 Hz screen_end frame strobe, so a short press is never missed between frames.
- Sits between the top-level button pins and the processor/VGA controller in the top-level wrapper.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive clock cycles a synchronised input must hold a new level before the debounced level changes (10 ms at 100 MHz); minimum 2.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset
- up  input  1  raw jump button, asynchronous to clock
- down  input  1  raw duck button, asynchronous to clock
- screen_end  input  1  one-cycle frame strobe from the VGA controller, synchronous to clock
- io_jump  output  1  jump request to the processor; held for exactly one frame
- duck  output  1  debounced level of down
- jump_pending  output  1  a debounced jump press is latched and not yet delivered
- jump_count  output  8  number of jumps delivered via io_jump, wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous):
  - All sync flops, debounce counters, pending latch and jump_count clear to 0.
  - Both debounce FSMs go to S_LOW.
  - Outputs after reset: io_jump=0, duck=0, jump_pending=0, jump_count=0.
  - Reset asserted mid-debounce or mid-frame aborts everything; no request survives reset.
- Synchroniser: each raw input passes through 2 flops. The FSM sees up_s/down_s, 2 cycles after the pin.
- Debounce FSM, one per button, states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW:
  - S_LOW: if sync=1, clear counter and go to S_WAIT_HIGH.
  - S_WAIT_HIGH: if sync=0, return to S_LOW with counter cleared. Otherwise increment; when counter reaches DEBOUNCE_CYCLES-1, go to S_HIGH.
  - S_HIGH: if sync=0, clear counter and go to S_WAIT_LOW.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH, exiting to S_LOW.
  - Debounced level = 1 in S_HIGH and S_WAIT_LOW, else 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no level change.
- Rising-edge detect on debounced up produces rise_up, a 1-cycle pulse on the S_WAIT_HIGH -> S_HIGH transition.
- duck is the debounced down level, registered; no frame alignment.
- Pending latch:
  - rise_up sets jump_pending on the next edge.
  - A second rise_up while pending has no effect; presses coalesce.
- Frame delivery, evaluated only in cycles where screen_end=1:
  - If jump_pending=1: io_jump<=1, jump_pending<=0, jump_count<=jump_count+1 (mod 256).
  - Else: io_jump<=0.
  - io_jump therefore changes only on the edge after a screen_end pulse and stays stable for a whole frame.
- Simultaneous rise_up and screen_end in the same cycle:
  - The strobe delivers the old pending state.
  - The new press sets jump_pending, to be delivered at the next screen_end.
  - The press is never lost.
- screen_end held high for several cycles is a testbench error; the block is not required to handle it.
- Latency, from up pin rising to jump_pending=1: 2 sync + DEBOUNCE_CYCLES + 1 cycles, then up to one frame to io_jump.

Test Plan (DEBOUNCE_CYCLES=4 for all benches):
- Reset: hold reset=0 with up=1, down=1 and screen_end pulsing -> io_jump=0, duck=0, jump_pending=0, jump_count=0 throughout; release reset with up=1 -> jump_pending rises exactly 2+4+1 cycles later.
- Glitch rejection: up pulses high for 3 cycles, low for 3, high for 3 -> jump_pending stays 0; down likewise -> duck stays 0.
- Clean press: up high 10 cycles, then screen_end pulse 20 cycles later -> jump_pending=1 until the strobe, io_jump=1 on the following edge, jump_count=1; next screen_end -> io_jump=0.
- Coalescing and wrap: three debounced presses between two strobes -> one delivery, jump_count+1 only. 256 separately-framed presses from count 0 -> jump_count returns to 0.
- Collision: time rise_up to the same cycle as screen_end with jump_pending=0 -> io_jump=0 for that frame, jump_pending=1, delivered on the next strobe.
- Mid-operation reset: assert reset while in S_WAIT_HIGH with jump_pending=1 and io_jump=1 -> all outputs 0 asynchronously; after release, no delivery until a new debounced press.
